// File: rtl/or1200_aes_arbiter.sv
// Shares one AES-128 core between the load and store encryption paths.
// Round-robin arbitration, core start/done sequencing, per-path pad registers and timeout flag.
module or1200_aes_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_req,
    input  logic [127:0] load_seed,
    output logic         load_gnt,
    output logic         load_done,
    output logic [127:0] load_pad,
    input  logic         store_req,
    input  logic [127:0] store_seed,
    output logic         store_gnt,
    output logic         store_done,
    output logic [127:0] store_pad,
    output logic         aes_start,
    output logic [127:0] aes_din,
    input  logic         aes_done,
    input  logic [127:0] aes_dout,
    output logic         busy,
    output logic         owner,
    output logic         timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e     state;
    logic [7:0] cnt;
    logic       last_grant;
    logic       req_l;
    logic       req_s;
    logic       any_req;
    logic       winner;

    // The requester just served is masked during DELIVER only.
    always_comb begin
        req_l   = load_req  && !(state == StDeliver && owner == 1'b0);
        req_s   = store_req && !(state == StDeliver && owner == 1'b1);
        any_req = req_l || req_s;
        winner  = (req_l && req_s) ? ~last_grant : req_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= 8'd0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            busy        <= 1'b0;
            aes_start   <= 1'b0;
            aes_din     <= '0;
            load_gnt    <= 1'b0;
            store_gnt   <= 1'b0;
            load_done   <= 1'b0;
            store_done  <= 1'b0;
            load_pad    <= '0;
            store_pad   <= '0;
            timeout_err <= 1'b0;
        end else begin
            aes_start  <= 1'b0;
            load_gnt   <= 1'b0;
            store_gnt  <= 1'b0;
            load_done  <= 1'b0;
            store_done <= 1'b0;
            unique case (state)
                StIdle, StDeliver: begin
                    if (any_req) begin
                        state      <= StIssue;
                        owner      <= winner;
                        last_grant <= winner;
                        aes_din    <= winner ? store_seed : load_seed;
                        aes_start  <= 1'b1;
                        load_gnt   <= ~winner;
                        store_gnt  <= winner;
                        busy       <= 1'b1;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StIssue: begin
                    cnt   <= 8'd0;
                    state <= StWait;
                end
                StWait: begin
                    if (aes_done) begin
                        if (owner) store_pad <= aes_dout;
                        else       load_pad  <= aes_dout;
                        timeout_err <= 1'b0;
                        load_done   <= ~owner;
                        store_done  <= owner;
                        state       <= StDeliver;
                    end else if (cnt == CntLast) begin
                        // Abort: pad keeps its previous value.
                        timeout_err <= 1'b1;
                        load_done   <= ~owner;
                        store_done  <= owner;
                        state       <= StDeliver;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/or1200_aes_arbiter.md
# or1200_aes_arbiter

- Shares one AES-128 core between the load-path and store-path encryption FSMs, replacing one core per path.
- Arbitrates seed/OFB pad requests round-robin and sequences the core's start/done handshake.
- Holds each path's most recent 128-bit pad and flags cores that fail to respond.
- Sits between the two encryption FSMs and the AES core inside the encryption top.

## Interface
Parameters:
- TIMEOUT, 64: maximum WAIT cycles before abort; legal range 2..255.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- load_req  in  1  level; held until load_done.
- load_seed  in  128  block to encrypt; sampled at grant.
- load_gnt  out  1  one-cycle pulse in the ISSUE cycle for load.
- load_done  out  1  one-cycle pulse in the DELIVER cycle for load.
- load_pad  out  128  last pad produced for load.
- store_req, store_seed, store_gnt, store_done, store_pad: same as the load ports, for the store path.
- aes_start  out  1  one-cycle start strobe to the core.
- aes_din  out  128  registered input block; stable from ISSUE through DELIVER.
- aes_done  in  1  core completion pulse.
- aes_dout  in  128  core result; valid when aes_done=1.
- busy  out  1  high in any state except IDLE.
- owner  out  1  0 = load, 1 = store; valid while busy.
- timeout_err  out  1  sticky abort flag.

## Operation
States and transitions:
- IDLE → ISSUE when any req is high and not masked. The arbiter picks the winner and latches seed into aes_din, owner and last_grant.
- ISSUE (1 cycle): aes_start=1, winner's gnt=1, wait counter cleared → WAIT.
- WAIT: counter increments each cycle.
  - aes_done=1: capture aes_dout into the owner's pad register → DELIVER.
  - counter reaches TIMEOUT-1 with no aes_done: set timeout_err, leave the pad unchanged → DELIVER.
- DELIVER (1 cycle): owner's done=1. Arbitration runs again with the just-served requester masked for this cycle only.
  - Any unmasked req: → ISSUE.
  - No unmasked req: → IDLE.

Arbitration:
- One request pending: it wins.
- Both pending: the requester not named by last_grant wins.
- last_grant resets to store, so load wins the first tie.

Boundary rules:
- req dropped before grant: no operation and no pulses.
- req dropped after grant: the operation completes; the pad updates and done still pulses.
- aes_done outside WAIT: ignored.
- aes_done in the same cycle as the counter reaching TIMEOUT-1: counts as success; no error.
- timeout_err clears only on rst or on the next successful capture.
- seed inputs change after grant: no effect, because aes_din is registered.

Reset, asynchronous at any state including mid-WAIT:
- State returns to IDLE.
- All outputs become 0: pads, aes_din, strobes, busy, owner, timeout_err.
- The counter clears and last_grant becomes store.

## Timing
- Cycle t: req sampled high in IDLE.
- Cycle t+1: ISSUE, with aes_start and gnt high.
- First WAIT cycle is t+2. With a core that raises aes_done L cycles after start (L ≥ 1, counting the start cycle as 0):
  - done and the new pad are visible at t+L+2.
  - Request-to-done latency is L+2.
- Back-to-back service: DELIVER to ISSUE is direct, so the period per operation is L+2 cycles.
- Timeout: done pulses TIMEOUT+1 cycles after the ISSUE cycle, and timeout_err is high from that DELIVER cycle onward.
- Pad outputs change only on the clock edge entering DELIVER and are otherwise stable.
- Counter is 8 bits and does not wrap, because the timeout exits WAIT first.

## Test plan
- Single load: load_req=1, load_seed=0x00112233_44556677_8899aabb_ccddeeff, core model L=11 → load_gnt at t+1; load_done at t+13; load_pad = model output; store outputs stay 0.
- Simultaneous requests after reset: load_req and store_req high at the same edge → load served first, then store served with its ISSUE in load's DELIVER+1 cycle; then alternation (store, load, …) while both stay high.
- Held request masked: store_req stays high one cycle past store_done with load_req low → store is not re-granted in DELIVER; it is re-granted on the following IDLE cycle.
- Timeout: core never asserts aes_done, TIMEOUT=8 → store_done 9 cycles after ISSUE; timeout_err=1; store_pad unchanged. The next good operation clears timeout_err.
- Reset mid-WAIT: assert rst 4 cycles after ISSUE → all outputs 0 immediately. A stale aes_done afterwards is ignored, and the first grant after release goes to load.
- Seed change after grant: alter load_seed during WAIT → aes_din unchanged; result matches the original seed.
